// File: rtl/vga_timing_pkg.sv
// Purpose : shared timing constants and types for the SVGA 800x600@56 Hz raster.
// Latency : n/a (package only).
// Backpressure: n/a; the raster is free-running.
package vga_timing_pkg;

  localparam int COORD_W = 10;
  localparam int COLOR_W = 4;

  // SVGA_800x600_56 timing
  localparam int SVGA_H_ACTIVE   = 800;
  localparam int SVGA_H_FRONT    = 24;
  localparam int SVGA_H_SYNC     = 72;
  localparam int SVGA_H_BACK     = 128;
  localparam int SVGA_V_ACTIVE   = 600;
  localparam int SVGA_V_FRONT    = 1;
  localparam int SVGA_V_SYNC     = 2;
  localparam int SVGA_V_BACK     = 22;
  localparam bit SVGA_H_SYNC_POL = 1'b1;
  localparam bit SVGA_V_SYNC_POL = 1'b1;

  localparam int SVGA_H_TOTAL = SVGA_H_ACTIVE + SVGA_H_FRONT + SVGA_H_SYNC + SVGA_H_BACK;
  localparam int SVGA_V_TOTAL = SVGA_V_ACTIVE + SVGA_V_FRONT + SVGA_V_SYNC + SVGA_V_BACK;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COLOR_W-1:0] color_t;

  // Syncs travel at pin level (polarity already applied).
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } sync_t;

  // Inclusive window test on a coordinate.
  function automatic logic in_window(coord_t c, coord_t lo, coord_t hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Purpose : DEPTH-stage shift register carrying {de, hs, vs} to match colour-source latency.
// Latency : DEPTH cycles (DEPTH = 0 is a wire-through).
// Backpressure: none; advances every pixel_clk.
// Ports   : pixel_clk, rst (async active-high), sync_in -> sync_out.
module vga_sync_delay
  import vga_timing_pkg::*;
#(
  parameter int DEPTH   = 1,
  parameter bit HS_IDLE = 1'b0,
  parameter bit VS_IDLE = 1'b0
) (
  input  logic  pixel_clk,
  input  logic  rst,
  input  sync_t sync_in,
  output sync_t sync_out
);

  localparam sync_t IDLE = '{de: 1'b0, hs: HS_IDLE, vs: VS_IDLE};

  if (DEPTH <= 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = pixel_clk ^ rst;
    assign sync_out       = sync_in;
  end else begin : g_pipe
    sync_t stage [DEPTH];

    always_ff @(posedge pixel_clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= IDLE;
      end else begin
        stage[0] <= sync_in;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign sync_out = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose : raster counters, sync/blank generation and registered VGA pin stage.
// Latency : counter (h,v) reaches the pins PIPE_DELAY+1 cycles later; coords/display_on are undelayed.
// Backpressure: none; free-running at pixel_clk, colour source must keep pace.
// Ports   : pixel_clk, rst (async active-high), red/green/blue_in from colour source;
//           h_coord, v_coord, display_on, frame_start, frame_cnt to game logic;
//           vga_hs, vga_vs, vga_r/g/b to the connector.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = SVGA_H_ACTIVE,
  parameter int H_FRONT    = SVGA_H_FRONT,
  parameter int H_SYNC     = SVGA_H_SYNC,
  parameter int H_BACK     = SVGA_H_BACK,
  parameter int V_ACTIVE   = SVGA_V_ACTIVE,
  parameter int V_FRONT    = SVGA_V_FRONT,
  parameter int V_SYNC     = SVGA_V_SYNC,
  parameter int V_BACK     = SVGA_V_BACK,
  parameter bit H_SYNC_POL = SVGA_H_SYNC_POL,
  parameter bit V_SYNC_POL = SVGA_V_SYNC_POL,
  parameter int PIPE_DELAY = 1
) (
  input  logic               pixel_clk,
  input  logic               rst,
  input  logic [COLOR_W-1:0] red_in,
  input  logic [COLOR_W-1:0] green_in,
  input  logic [COLOR_W-1:0] blue_in,
  output logic [COORD_W-1:0] h_coord,
  output logic [COORD_W-1:0] v_coord,
  output logic               display_on,
  output logic               frame_start,
  output logic [15:0]        frame_cnt,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT_C  = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT_C  = coord_t'(V_ACTIVE);
  localparam coord_t HS_FIRST = coord_t'(H_ACTIVE + H_FRONT);
  localparam coord_t HS_LAST  = coord_t'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_FIRST = coord_t'(V_ACTIVE + V_FRONT);
  localparam coord_t VS_LAST  = coord_t'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_bad_pipe_delay
    $error("vga_timing_gen: PIPE_DELAY must be in 0..4");
  end

  // ---------------------------------------------------------------- counters
  logic h_last;
  logic v_last;

  assign h_last = (h_coord == H_LAST);
  assign v_last = (v_coord == V_LAST);

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      h_coord   <= '0;
      v_coord   <= '0;
      frame_cnt <= '0;
    end else begin
      if (h_last) begin
        h_coord <= '0;
        v_coord <= v_last ? '0 : v_coord + 1'b1;
      end else begin
        h_coord <= h_coord + 1'b1;
      end
      if (h_last && v_last) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // ------------------------------------------------------- raw (undelayed)
  logic  de_raw;
  logic  hs_act;
  logic  vs_act;
  sync_t sync_raw;
  sync_t sync_d;

  assign de_raw = (h_coord < H_ACT_C) && (v_coord < V_ACT_C);
  assign hs_act = in_window(h_coord, HS_FIRST, HS_LAST);
  // vsync spans whole lines, so only v is examined.
  assign vs_act = in_window(v_coord, VS_FIRST, VS_LAST);

  assign display_on  = de_raw;
  assign frame_start = (h_coord == '0) && (v_coord == '0);

  // Polarity is applied before the delay line so its reset value is simply the idle pin level.
  assign sync_raw.de = de_raw;
  assign sync_raw.hs = hs_act ? H_SYNC_POL : ~H_SYNC_POL;
  assign sync_raw.vs = vs_act ? V_SYNC_POL : ~V_SYNC_POL;

  vga_sync_delay #(
    .DEPTH   (PIPE_DELAY),
    .HS_IDLE (~H_SYNC_POL),
    .VS_IDLE (~V_SYNC_POL)
  ) u_sync_delay (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .sync_in   (sync_raw),
    .sync_out  (sync_d)
  );

  // ------------------------------------------------------------ pin stage
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      vga_hs <= ~H_SYNC_POL;
      vga_vs <= ~V_SYNC_POL;
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
    end else begin
      vga_hs <= sync_d.hs;
      vga_vs <= sync_d.vs;
      vga_r  <= sync_d.de ? red_in   : '0;
      vga_g  <= sync_d.de ? green_in : '0;
      vga_b  <= sync_d.de ? blue_in  : '0;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Produces the SVGA 800x600@56 Hz raster that drives the game logic and the VGA connector.
- Generates pixel counters h_coord/v_coord, which feed the game logic directly.
- Takes the game logic's registered 4-bit RGB back in, blanks it outside the active area, and drives the VGA pins.
- Delays hsync, vsync and display-enable so they stay aligned with the pixel pipeline.
- Provides frame_start and a frame counter for housekeeping.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FRONT, 24, horizontal front porch (pixels)
H_SYNC, 72, hsync pulse width (pixels)
H_BACK, 128, horizontal back porch (pixels); H_TOTAL = 1024
V_ACTIVE, 600, visible lines
V_FRONT, 1, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 22, vertical back porch (lines); V_TOTAL = 625
H_SYNC_POL, 1, hsync active level
V_SYNC_POL, 1, vsync active level
PIPE_DELAY, 1, colour-source latency in cycles, legal range 0..4

Ports:
pixel_clk  in  1  pixel clock, 36 MHz
rst  in  1  reset, asynchronous, active-high
red_in  in  4  red from colour source
green_in  in  4  green from colour source
blue_in  in  4  blue from colour source
h_coord  out  10  horizontal counter, 0..H_TOTAL-1
v_coord  out  10  vertical counter, 0..V_TOTAL-1
display_on  out  1  counters are inside the active area (undelayed)
frame_start  out  1  high while counters are at (0,0)
frame_cnt  out  16  completed-frame count
vga_hs  out  1  horizontal sync pin
vga_vs  out  1  vertical sync pin
vga_r  out  4  red pin
vga_g  out  4  green pin
vga_b  out  4  blue pin

Behaviour:
Interface:
- One clock, pixel_clk.
- Reset rst is asynchronous and active-high. All registers clear on rst assertion, without waiting for a clock edge.

Reset state:
- h_coord = 0, v_coord = 0, frame_cnt = 0.
- vga_r/g/b = 0.
- vga_hs = !H_SYNC_POL, vga_vs = !V_SYNC_POL.
- Delay-line contents are all inactive (de = 0, syncs at inactive level).

Counters:
- h_coord increments every cycle and wraps from H_TOTAL-1 to 0.
- v_coord increments when h_coord wraps, and wraps from V_TOTAL-1 to 0 on that same cycle.

Raw (undelayed) signals, combinational from the counters:
- de_raw = (h < H_ACTIVE) && (v < V_ACTIVE). display_on = de_raw.
- hs_raw is active for h in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1], i.e. [824, 895].
- vs_raw is active for v in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1], i.e. lines 601..602. It covers whole lines, h = 0..1023.

frame_start:
- frame_start = (h == 0 && v == 0).
- It is also high in the first cycle after reset release; this is intended.

frame_cnt:
- Increments on the cycle the counters are at (H_TOTAL-1, V_TOTAL-1).
- Wraps modulo 2^16.

Alignment and output stage:
- hs_raw, vs_raw and de_raw pass through a PIPE_DELAY-stage shift register.
- At PIPE_DELAY = 0 the shift register is a bypass.
- Then one output register stage:
  - vga_hs <= hs_d, driven at the active level given by H_SYNC_POL.
  - vga_vs <= vs_d, driven at the active level given by V_SYNC_POL.
  - vga_r <= de_d ? red_in : 0; vga_g and vga_b are formed the same way.

Latency:
- A counter value (h, v) in cycle t appears on the pins at cycle t + PIPE_DELAY + 1, for both syncs and colour.
- The colour source must present the colour for (h, v) at cycle t + PIPE_DELAY.

Boundary conditions:
- Blanking: no nonzero RGB reaches the pins outside the active area, whatever red_in/green_in/blue_in carry.
- Reset mid-frame: counters return to (0,0), pins go inactive at once, and the delay line flushes. After release the first pin-level active pixel appears PIPE_DELAY+1 cycles after the (0,0) cycle.
- Coordinate range: counters never exceed H_TOTAL-1 / V_TOTAL-1.
- Unsupported configuration: PIPE_DELAY outside 0..4 is a configuration error, checked by an elaboration-time assertion.

Decomposition:
- Shared package vga_timing_pkg:
  - SVGA_800x600_56 timing constants (active, porches, sync widths, polarities).
  - Derived H_TOTAL and V_TOTAL.
  - COORD_W = 10 and COLOR_W = 4.
- One sub-module, vga_sync_delay: parameterised-depth shift register carrying {de, hs, vs}.
  - Reset values are de = 0 and inactive sync levels.
  - Depth 0 is a wire-through.

Test Plan:
- Reset hold, then release: all outputs at reset values; frame_start = 1 in the first cycle; h_coord steps 0, 1, 2, ...; h wraps to 0 after 1023, when v becomes 1.
- Line timing, PIPE_DELAY = 1: vga_hs rises 826 cycles after an h = 0 cycle and stays high 72 cycles; period 1024 cycles.
- Frame timing: vga_vs is high for exactly 2048 consecutive cycles per frame, rising 601×1024 + 2 cycles after frame_start. Frame period 640000 cycles; frame_cnt = 2 after 1280000 cycles.
- Blanking, red_in = green_in = blue_in = 4'hF constant: pins are F for exactly 800 cycles per line on lines 0..599 and 0 elsewhere. The first F appears 2 cycles after (0,0).
- Alignment: colour source models 1-cycle latency, outputting red = h[3:0]. The pin value equals (h_pin − h_first) mod 16 across a line. Repeat with PIPE_DELAY = 0 using combinational source red = h[3:0].
- Asynchronous reset mid-line at h = 400, v = 300, asserted between clock edges: outputs clear before the next edge; after release, counting restarts at (0,0) and frame_cnt = 0.
